// File: rtl/block_writer_if.sv
// Bundle of the block writer's request, RAM-read and SRAM-write signals.
// master = the writer itself, slave = the surrounding system / bench.
interface block_writer_if;
    logic        start;
    logic [17:0] base_address;
    logic [5:0]  ram_address;
    logic [31:0] ram_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        done;

    modport master (
        input  start, base_address, ram_read_data,
        output ram_address, SRAM_address, SRAM_write_data, SRAM_we_n, busy, done
    );

    modport slave (
        output start, base_address, ram_read_data,
        input  ram_address, SRAM_address, SRAM_write_data, SRAM_we_n, busy, done
    );
endinterface

// File: rtl/block_writer.sv
// Streams one 8x8 post-IDCT block from the local RAM into SRAM as clipped pixel pairs.
// Latency: done pulses 67 cycles after the accepted start; starts while busy are dropped.
module block_writer #(
    parameter int unsigned ROW_STRIDE = 160
) (
    input  logic           CLOCK_50_I,
    input  logic           resetn,
    block_writer_if.master bw
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    localparam logic [17:0] STRIDE = 18'(ROW_STRIDE);

    state_t      state_q;
    logic [17:0] base_q;
    logic [17:0] row_off_q;
    logic [1:0]  col_q;
    logic [5:0]  ram_addr_q;
    logic [5:0]  rd_idx_q;
    logic        rd_vld_q;
    logic        last_wr_q;
    logic [7:0]  hi_q;
    logic [17:0] sram_addr_q;
    logic [15:0] sram_dat_q;
    logic        we_n_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  pix_d;
    logic [17:0] wr_addr_d;

    function automatic logic [7:0] clip(input logic [31:0] v);
        if (v[31])
            return 8'd0;
        else if (v[30:8] != '0)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    assign pix_d     = clip(bw.ram_read_data);
    assign wr_addr_d = base_q + row_off_q + {16'd0, col_q};

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            row_off_q   <= '0;
            col_q       <= '0;
            ram_addr_q  <= '0;
            rd_idx_q    <= '0;
            rd_vld_q    <= 1'b0;
            last_wr_q   <= 1'b0;
            hi_q        <= '0;
            sram_addr_q <= '0;
            sram_dat_q  <= '0;
            we_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            we_n_q   <= 1'b1;
            done_q   <= 1'b0;
            // RAM data lags the address by one cycle; track which index it belongs to.
            rd_vld_q <= (state_q == S_FETCH);
            rd_idx_q <= ram_addr_q;

            if (rd_vld_q) begin
                if (!rd_idx_q[0]) begin
                    hi_q <= pix_d;
                end else begin
                    sram_addr_q <= wr_addr_d;
                    sram_dat_q  <= {hi_q, pix_d};
                    we_n_q      <= 1'b0;
                    col_q       <= col_q + 2'd1;
                    if (col_q == 2'd3)
                        row_off_q <= row_off_q + STRIDE;
                    last_wr_q   <= (rd_idx_q == 6'd63);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bw.start) begin
                        state_q    <= S_FETCH;
                        base_q     <= bw.base_address;
                        ram_addr_q <= '0;
                        row_off_q  <= '0;
                        col_q      <= '0;
                        last_wr_q  <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (ram_addr_q == 6'd63)
                        state_q <= S_DRAIN;
                    else
                        ram_addr_q <= ram_addr_q + 6'd1;
                end
                S_DRAIN: begin
                    if (last_wr_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    last_wr_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bw.ram_address     = ram_addr_q;
    assign bw.SRAM_address    = sram_addr_q;
    assign bw.SRAM_write_data = sram_dat_q;
    assign bw.SRAM_we_n       = we_n_q;
    assign bw.busy            = busy_q;
    assign bw.done            = done_q;

endmodule

// File: tb/tb_block_writer.sv
// Randomised bench for block_writer: a cycle-indexed reference of the expected
// SRAM write stream is compared against the DUT on every cycle of each block.
module tb_block_writer;

    localparam int STRIDE = 160;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    block_writer_if bw();

    block_writer #(.ROW_STRIDE(STRIDE)) dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bw         (bw)
    );

    always #5 clk = ~clk;

    int ram_mem [64];

    // Synchronous-read RAM: data appears one cycle after the address.
    always @(posedge clk) bw.ram_read_data <= ram_mem[bw.ram_address];

    int n_checks = 0;
    int n_errs   = 0;

    logic [17:0] exp_addr;
    logic [15:0] exp_dat;
    logic [5:0]  exp_idle_ra;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_clip(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 2))
                0:       ram_mem[i] = int'($urandom);
                1:       ram_mem[i] = int'($urandom_range(0, 900)) - 300;
                default: ram_mem[i] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Runs one block starting with start driven in C0. Optional re-pulses of
    // start at C10/C40 and an asynchronous reset at cycle abort_at (0 = none).
    task automatic run_block(input logic [17:0] base, input bit restarts, input int abort_at);
        bit wr;
        int j;
        @(negedge clk);
        chk("idle_busy", bw.busy, 0);
        chk("idle_done", bw.done, 0);
        chk("idle_we_n", bw.SRAM_we_n, 1);
        chk("idle_ram_addr", bw.ram_address, exp_idle_ra);
        chk("idle_sram_addr", bw.SRAM_address, exp_addr);
        chk("idle_sram_dat", bw.SRAM_write_data, exp_dat);
        bw.start        = 1'b1;
        bw.base_address = base;
        for (int k = 1; k <= 67; k++) begin
            @(negedge clk);
            bw.start = 1'b0;
            if (restarts && (k == 10 || k == 40)) begin
                bw.start        = 1'b1;
                bw.base_address = base ^ 18'h2AAAA ^ 18'(k);
            end
            wr = (k >= 4) && (k <= 66) && (k % 2 == 0);
            if (wr) begin
                j        = (k - 4) / 2;
                exp_addr = 18'(int'(base) + (j / 4) * STRIDE + (j % 4));
                exp_dat  = {ref_clip(ram_mem[2*j]), ref_clip(ram_mem[2*j+1])};
            end
            chk($sformatf("we_n@C%0d", k), bw.SRAM_we_n, !wr);
            chk($sformatf("sram_addr@C%0d", k), bw.SRAM_address, exp_addr);
            chk($sformatf("sram_dat@C%0d", k), bw.SRAM_write_data, exp_dat);
            chk($sformatf("busy@C%0d", k), bw.busy, 1);
            chk($sformatf("done@C%0d", k), bw.done, (k == 67));
            chk($sformatf("ram_addr@C%0d", k), bw.ram_address, (k - 1 > 63) ? 63 : k - 1);
            if (k == abort_at) begin
                resetn = 1'b0;
                #1;
                chk("abort_we_n", bw.SRAM_we_n, 1);
                chk("abort_busy", bw.busy, 0);
                chk("abort_done", bw.done, 0);
                chk("abort_sram_addr", bw.SRAM_address, 0);
                chk("abort_ram_addr", bw.ram_address, 0);
                exp_addr    = '0;
                exp_dat     = '0;
                exp_idle_ra = '0;
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk);
                    chk("abort_hold_we_n", bw.SRAM_we_n, 1);
                    chk("abort_hold_done", bw.done, 0);
                end
                resetn = 1'b1;
                return;
            end
        end
        exp_idle_ra = 6'd63;
    endtask

    initial begin
        bw.start        = 1'b0;
        bw.base_address = '0;
        for (int i = 0; i < 64; i++) ram_mem[i] = 0;
        exp_addr    = '0;
        exp_dat     = '0;
        exp_idle_ra = '0;

        repeat (3) @(negedge clk);
        chk("rst_we_n", bw.SRAM_we_n, 1);
        chk("rst_busy", bw.busy, 0);
        chk("rst_done", bw.done, 0);
        chk("rst_sram_addr", bw.SRAM_address, 0);
        chk("rst_sram_dat", bw.SRAM_write_data, 0);
        chk("rst_ram_addr", bw.ram_address, 0);
        resetn = 1'b1;

        // Ramp data at base 0.
        for (int i = 0; i < 64; i++) ram_mem[i] = i;
        run_block(18'h0, 1'b0, 0);

        // Clipping corner values.
        fill_random();
        ram_mem[0] = -5;
        ram_mem[1] = 256;
        ram_mem[2] = 255;
        ram_mem[3] = 0;
        ram_mem[4] = int'(32'h8000_0000);
        ram_mem[5] = int'(32'h7FFF_FFFF);
        run_block(18'($urandom), 1'b0, 0);

        // Constant mid-grey at a fixed base, then a back-to-back random block.
        for (int i = 0; i < 64; i++) ram_mem[i] = 128;
        run_block(18'h12345, 1'b0, 0);
        fill_random();
        run_block(18'($urandom), 1'b0, 0);

        // Starts while busy must be ignored.
        fill_random();
        run_block(18'($urandom), 1'b1, 0);

        // Abort mid-block, then a full block after release.
        fill_random();
        run_block(18'($urandom), 1'b0, 30);
        fill_random();
        run_block(18'($urandom), 1'b0, 0);

        // Random blocks, one near the top of the address space to exercise wrap.
        for (int b = 0; b < 4; b++) begin
            fill_random();
            run_block((b == 2) ? 18'h3FF80 : 18'($urandom), 1'b0, 0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("final_busy", bw.busy, 0);
        chk("final_done", bw.done, 0);
        chk("final_we_n", bw.SRAM_we_n, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
